// File: rtl/fir_stream_engine.sv
// Block-based streaming FIR engine: reads N samples from memory, filters them, writes N results.
// Define FIR_SAT_EN to saturate results to DW bits; by default results wrap to the low DW bits.

module fir_stream_engine #(
  parameter int DW    = 8,
  parameter int CW    = 8,
  parameter int NTAPS = 5,
  parameter int AW    = 10
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     start,
  input  logic [AW-1:0]            input_addr,
  input  logic [AW-1:0]            output_addr,
  input  logic [AW-1:0]            sample_count,
  input  logic [4:0]               out_shift,
  input  logic                     coef_we,
  input  logic [$clog2(NTAPS)-1:0] coef_idx,
  input  logic [CW-1:0]            coef_data,
  output logic                     busy,
  output logic                     done,
  output logic [AW-1:0]            mem_addr_a,
  input  logic [DW-1:0]            mem_data_out_a,
  output logic [AW-1:0]            mem_addr_b,
  output logic [DW-1:0]            mem_data_in_b,
  output logic                     mem_we_b
);

  localparam int IW   = $clog2(NTAPS);
  localparam int PW   = DW + CW;
  localparam int AccW = DW + CW + $clog2(NTAPS);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  state_t state, state_next;

  logic [AW-1:0]          in_base, out_base, blk_count, rd_cnt, wr_cnt;
  logic [4:0]             blk_shift;
  logic                   v_data, v_tap, v_prod, v_acc;
  logic signed [DW-1:0]   taps  [NTAPS];
  logic signed [CW-1:0]   coef  [NTAPS];
  logic signed [PW-1:0]   prods [NTAPS];
  logic signed [AccW-1:0] acc, sum;
  logic                   accept, last_rd, last_wr;

  assign accept  = (state == IDLE) && start;
  assign last_rd = (rd_cnt == blk_count - AW'(1));
  assign last_wr = v_acc && (wr_cnt == blk_count - AW'(1));

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = (sample_count == '0) ? DONE : RUN;
      RUN:     if (last_rd) state_next = DRAIN;
      DRAIN:   if (last_wr) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    busy       = (state == RUN) || (state == DRAIN);
    done       = (state == DONE);
    mem_addr_a = (state == RUN) ? in_base + rd_cnt : '0;
  end

  // Pipeline: read data -> tap shift -> product register -> sum register, write in the following cycle.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      in_base   <= '0;
      out_base  <= '0;
      blk_count <= '0;
      blk_shift <= '0;
      rd_cnt    <= '0;
      wr_cnt    <= '0;
      v_data    <= 1'b0;
      v_tap     <= 1'b0;
      v_prod    <= 1'b0;
      v_acc     <= 1'b0;
      acc       <= '0;
      for (int k = 0; k < NTAPS; k++) begin
        taps[k]  <= '0;
        prods[k] <= '0;
      end
    end else begin
      if (accept) begin
        in_base   <= input_addr;
        out_base  <= output_addr;
        blk_count <= sample_count;
        blk_shift <= out_shift;
        rd_cnt    <= '0;
        wr_cnt    <= '0;
      end else begin
        if (state == RUN) rd_cnt <= rd_cnt + AW'(1);
        if (v_acc)        wr_cnt <= wr_cnt + AW'(1);
      end

      v_data <= (state == RUN);
      v_tap  <= v_data;
      v_prod <= v_tap;
      v_acc  <= v_prod;

      if (accept) begin
        for (int k = 0; k < NTAPS; k++) taps[k] <= '0;
      end else if (v_data) begin
        taps[0] <= mem_data_out_a;
        for (int k = 1; k < NTAPS; k++) taps[k] <= taps[k-1];
      end

      for (int k = 0; k < NTAPS; k++) prods[k] <= PW'(coef[k]) * PW'(taps[k]);
      acc <= sum;
    end
  end

  always_comb begin
    sum = '0;
    for (int k = 0; k < NTAPS; k++) sum = sum + AccW'(prods[k]);
  end

  // Coefficients are frozen while a block runs so a block always sees one consistent filter.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int k = 0; k < NTAPS; k++) coef[k] <= '0;
    end else if (coef_we && !busy && ({1'b0, coef_idx} < (IW+1)'(NTAPS))) begin
      coef[coef_idx] <= coef_data;
    end
  end

  assign mem_we_b   = v_acc;
  assign mem_addr_b = v_acc ? out_base + wr_cnt : '0;

`ifdef FIR_SAT_EN
  localparam logic signed [AccW-1:0] SAT_MAX = AccW'((2 ** (DW - 1)) - 1);
  localparam logic signed [AccW-1:0] SAT_MIN = AccW'(-(2 ** (DW - 1)));

  logic signed [AccW-1:0] shifted;

  always_comb begin
    shifted = acc >>> blk_shift;
    if (shifted > SAT_MAX)      mem_data_in_b = SAT_MAX[DW-1:0];
    else if (shifted < SAT_MIN) mem_data_in_b = SAT_MIN[DW-1:0];
    else                        mem_data_in_b = shifted[DW-1:0];
  end
`else
  assign mem_data_in_b = DW'(acc >>> blk_shift);
`endif

endmodule

// File: tb/tb_fir_stream_engine.sv
// Bench for fir_stream_engine: spec vector table, hand-written corner cases and random blocks
// checked against a plain-arithmetic convolution model.

module tb_fir_stream_engine;

  localparam int DW    = 8;
  localparam int CW    = 8;
  localparam int NTAPS = 5;
  localparam int AW    = 10;
  localparam int IW    = $clog2(NTAPS);
  localparam int MEMSZ = 1 << AW;

  typedef struct packed {
    logic [NTAPS-1:0][7:0] coefs;
    logic [4:0]            shift;
    logic [3:0]            n;
    logic [9:0]            in_base;
    logic [9:0]            out_base;
    logic [7:0][7:0]       xin;
    logic [7:0][7:0]       yexp;
  } vec_t;

  logic          clk, rst_n, start, coef_we, busy, done, mem_we_b;
  logic [AW-1:0] input_addr, output_addr, sample_count, mem_addr_a, mem_addr_b;
  logic [4:0]    out_shift;
  logic [IW-1:0] coef_idx;
  logic [CW-1:0] coef_data;
  logic [DW-1:0] mem_data_out_a, mem_data_in_b;

  fir_stream_engine #(.DW(DW), .CW(CW), .NTAPS(NTAPS), .AW(AW)) dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .input_addr(input_addr), .output_addr(output_addr), .sample_count(sample_count),
    .out_shift(out_shift), .coef_we(coef_we), .coef_idx(coef_idx), .coef_data(coef_data),
    .busy(busy), .done(done),
    .mem_addr_a(mem_addr_a), .mem_data_out_a(mem_data_out_a),
    .mem_addr_b(mem_addr_b), .mem_data_in_b(mem_data_in_b), .mem_we_b(mem_we_b)
  );

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;
  int done_cnt = 0;
  int busy_done_overlap = 0;
  int wa_q[$], wd_q[$], wc_q[$];
  int h_model[NTAPS];
  int x_model[$];
  logic [DW-1:0] mem [MEMSZ];
  vec_t vecs[3];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Read port of the sample memory: data one cycle after the address.
  always @(posedge clk) begin
    cyc <= cyc + 1;
    mem_data_out_a <= mem[mem_addr_a];
  end

  always @(negedge clk) begin
    if (mem_we_b) begin
      wa_q.push_back(int'(mem_addr_b));
      wd_q.push_back(int'($signed(mem_data_in_b)));
      wc_q.push_back(cyc);
    end
    if (done) done_cnt <= done_cnt + 1;
    if (done && busy) busy_done_overlap <= busy_done_overlap + 1;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: actual timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic check_output(input string name, input int actual, input int expected);
    n_checks++;
    if (actual == expected) n_pass++;
    else $display("[TB] FAIL %s: actual %0d expected %0d", name, actual, expected);
  endtask

  function automatic int model_y(input int i, input int shift);
    longint acc;
    acc = 0;
    for (int k = 0; k < NTAPS; k++)
      if (i - k >= 0) acc += longint'(h_model[k]) * longint'(x_model[i-k]);
    acc = acc >>> shift;
`ifdef FIR_SAT_EN
    if (acc > longint'((1 << (DW - 1)) - 1)) acc = longint'((1 << (DW - 1)) - 1);
    if (acc < -longint'(1 << (DW - 1)))      acc = -longint'(1 << (DW - 1));
    return int'(acc);
`else
    return int'($signed(acc[DW-1:0]));
`endif
  endfunction

  task automatic write_coef(input int idx, input int val);
    @(negedge clk);
    coef_we = 1'b1; coef_idx = IW'(idx); coef_data = CW'(val);
    @(negedge clk);
    coef_we = 1'b0;
    if (idx < NTAPS) h_model[idx] = val;
  endtask

  task automatic apply_stimulus(input int in_base, input int out_base, input int n,
                                input int shift, output int start_cyc);
    @(negedge clk);
    start = 1'b1;
    input_addr = AW'(in_base); output_addr = AW'(out_base);
    sample_count = AW'(n); out_shift = 5'(shift);
    start_cyc = cyc;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic run_and_check(input string tag, input int in_base, input int out_base,
                               input int n, input int shift, input bit use_tab,
                               input logic [7:0][7:0] yexp);
    int start_cyc, base, waited, expv;
    for (int j = 0; j < n; j++) mem[(in_base + j) % MEMSZ] = DW'(x_model[j]);
    base = wa_q.size();
    apply_stimulus(in_base, out_base, n, shift, start_cyc);
    check_output({tag, " busy after accept"}, int'(busy), (n > 0) ? 1 : 0);
    waited = 0;
    while (!done && waited < 300) begin
      @(negedge clk);
      waited++;
    end
    check_output({tag, " done seen"}, int'(done), 1);
    check_output({tag, " done latency"}, cyc - start_cyc, (n == 0) ? 1 : n + 5);
    repeat (3) @(negedge clk);
    check_output({tag, " write count"}, wa_q.size() - base, n);
    for (int i = 0; i < n && base + i < wa_q.size(); i++) begin
      expv = use_tab ? int'($signed(yexp[i])) : model_y(i, shift);
      check_output($sformatf("%s y[%0d]", tag, i), wd_q[base+i], expv);
      check_output($sformatf("%s addr[%0d]", tag, i), wa_q[base+i], (out_base + i) % MEMSZ);
      check_output($sformatf("%s wcyc[%0d]", tag, i), wc_q[base+i] - start_cyc, i + 5);
    end
  endtask

  task automatic load_vec(input int v);
    for (int k = 0; k < NTAPS; k++) write_coef(k, int'($signed(vecs[v].coefs[k])));
    x_model.delete();
    for (int j = 0; j < int'(vecs[v].n); j++) x_model.push_back(int'($signed(vecs[v].xin[j])));
  endtask

  initial begin
    int base, d0, sc;
    start = 1'b0; coef_we = 1'b0; coef_idx = '0; coef_data = '0;
    input_addr = '0; output_addr = '0; sample_count = '0; out_shift = '0;
    for (int a = 0; a < MEMSZ; a++) mem[a] = '0;
    for (int k = 0; k < NTAPS; k++) h_model[k] = 0;

    vecs[0].coefs = {8'd1, 8'd2, 8'd3, 8'd2, 8'd1};
    vecs[0].shift = 5'd0; vecs[0].n = 4'd8; vecs[0].in_base = 10'h100; vecs[0].out_base = 10'h200;
    vecs[0].xin   = {8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd1};
    vecs[0].yexp  = {8'd0, 8'd0, 8'd0, 8'd1, 8'd2, 8'd3, 8'd2, 8'd1};
    vecs[1].coefs = {5{8'd1}};
    vecs[1].shift = 5'd2; vecs[1].n = 4'd6; vecs[1].in_base = 10'h300; vecs[1].out_base = 10'h340;
    vecs[1].xin   = {8{8'd20}};
    vecs[1].yexp  = {8'd0, 8'd0, 8'd25, 8'd25, 8'd20, 8'd15, 8'd10, 8'd5};
    vecs[2].coefs = {5{8'd127}};
    vecs[2].shift = 5'd0; vecs[2].n = 4'd5; vecs[2].in_base = 10'h3FE; vecs[2].out_base = 10'h1FE;
    vecs[2].xin   = {8{8'd100}};
`ifdef FIR_SAT_EN
    vecs[2].yexp  = {8'd0, 8'd0, 8'd0, 8'd127, 8'd127, 8'd127, 8'd127, 8'd127};
`else
    vecs[2].yexp  = {8'd0, 8'd0, 8'd0, 8'd12, 8'd112, 8'hD4, 8'd56, 8'h9C};
`endif

    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check_output("reset busy", int'(busy), 0);
    check_output("reset done", int'(done), 0);
    check_output("reset mem_we_b", int'(mem_we_b), 0);
    check_output("reset mem_addr_a", int'(mem_addr_a), 0);
    check_output("reset mem_addr_b", int'(mem_addr_b), 0);
    rst_n = 1'b1;
    @(negedge clk);

    // Spec vectors; out-of-range coefficient indices are written each time and must be ignored.
    for (int v = 0; v < 3; v++) begin
      load_vec(v);
      write_coef(NTAPS + v, 99);
      run_and_check($sformatf("vec%0d", v), int'(vecs[v].in_base), int'(vecs[v].out_base),
                    int'(vecs[v].n), int'(vecs[v].shift), 1'b1, vecs[v].yexp);
    end

    x_model.delete();
    run_and_check("empty block", 10'h050, 10'h060, 0, 0, 1'b0, '0);

    // start and coef_we while busy must not disturb the running block.
    load_vec(0);
    base = wa_q.size();
    fork
      run_and_check("busy ignore", 10'h100, 10'h200, 8, 0, 1'b1, vecs[0].yexp);
      begin
        repeat (3) @(negedge clk);
        start = 1'b1; input_addr = 10'h000; sample_count = 10'd3;
        coef_we = 1'b1; coef_idx = '0; coef_data = 8'd50;
        @(negedge clk);
        start = 1'b0; coef_we = 1'b0;
      end
    join
    repeat (10) @(negedge clk);
    check_output("busy ignore total writes", wa_q.size() - base, 8);
    check_output("busy ignore idle after", int'(busy), 0);

    // Reset during the fourth RUN cycle aborts the block and clears the coefficients.
    load_vec(0);
    for (int j = 0; j < 8; j++) mem[(10'h100 + j) % MEMSZ] = DW'(x_model[j]);
    base = wa_q.size();
    d0 = done_cnt;
    apply_stimulus(10'h100, 10'h200, 8, 0, sc);
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    check_output("abort busy", int'(busy), 0);
    check_output("abort done", int'(done), 0);
    check_output("abort mem_addr_a", int'(mem_addr_a), 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (15) @(negedge clk);
    check_output("abort writes", wa_q.size() - base, 0);
    check_output("abort done pulses", done_cnt - d0, 0);
    for (int k = 0; k < NTAPS; k++) h_model[k] = 0;
    run_and_check("zero coefs", 10'h100, 10'h200, 8, 0, 1'b0, '0);
    load_vec(0);
    run_and_check("after abort", 10'h100, 10'h200, 8, 0, 1'b1, vecs[0].yexp);

    for (int r = 0; r < 6; r++) begin
      int n, sh, ib;
      for (int k = 0; k < NTAPS; k++) write_coef(k, int'($urandom_range(0, 255)) - 128);
      n  = int'($urandom_range(1, 12));
      sh = int'($urandom_range(0, 9));
      ib = int'($urandom_range(0, MEMSZ - 1));
      x_model.delete();
      for (int j = 0; j < n; j++) x_model.push_back(int'($urandom_range(0, 255)) - 128);
      run_and_check($sformatf("rand%0d", r), ib, (ib + 512) % MEMSZ, n, sh, 1'b0, '0);
    end

    check_output("done never with busy", busy_done_overlap, 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
